// File: rtl/rom_loader.sv
// Boot-time firmware writer: assembles big-endian words from a byte stream and writes them to the ROM.
// Optional trailing XOR checksum byte enabled by ROM_LOADER_CHECKSUM_EN.
module rom_loader #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  rom_write_enable,
  output logic [ADDR_WIDTH-1:0] rom_write_address,
  output logic [DATA_WIDTH-1:0] rom_write_data,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_error,
  output logic                  cpu_enable
);

  localparam int unsigned CNT_W    = ADDR_WIDTH + 1;
  localparam int unsigned CAPACITY = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      n_q, n_d;
  logic [CNT_W-1:0]      index_q, index_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [23:0]           word_q, word_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  byte_ready_q, byte_ready_d;
  logic                  wr_en_q, wr_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  cpu_en_q, cpu_en_d;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  logic accept;
  assign accept = byte_valid && byte_ready_q;

  // Next-state and datapath updates; outputs are derived from the next state so they register with it.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    index_d    = index_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    addr_d     = addr_q;
    data_d     = data_q;
`ifdef ROM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_HEADER;
      end
      S_HEADER: begin
        if (accept) begin
          if ((byte_in == 8'd0) || (32'(byte_in) > CAPACITY)) begin
            state_d = S_ERROR;
          end else begin
            n_d        = CNT_W'(byte_in);
            index_d    = '0;
            byte_cnt_d = '0;
`ifdef ROM_LOADER_CHECKSUM_EN
            csum_d     = '0;
`endif
            state_d    = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
`ifdef ROM_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ byte_in;
`endif
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            data_d  = DATA_WIDTH'({word_q, byte_in});
            addr_d  = index_q[ADDR_WIDTH-1:0];
            state_d = S_WRITE;
          end else begin
            word_d = {word_q[15:0], byte_in};
          end
        end
      end
      S_WRITE: begin
        index_d = index_q + CNT_W'(1);
        if (index_d == n_q) begin
`ifdef ROM_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) state_d = (byte_in == csum_q) ? S_DONE : S_ERROR;
      end
`endif
      S_DONE, S_ERROR: begin
        if (start) state_d = S_HEADER;
      end
      default: state_d = S_IDLE;
    endcase

    byte_ready_d = (state_d == S_HEADER) || (state_d == S_DATA) || (state_d == S_CHECK);
    wr_en_d      = (state_d == S_WRITE);
    busy_d       = byte_ready_d || wr_en_d;
    done_d       = (state_d == S_DONE);
    cpu_en_d     = (state_d == S_DONE);
    error_d      = (state_d == S_ERROR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      index_q      <= '0;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cpu_en_q     <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      index_q      <= index_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      byte_ready_q <= byte_ready_d;
      wr_en_q      <= wr_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      cpu_en_q     <= cpu_en_d;
`ifdef ROM_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign byte_ready        = byte_ready_q;
  assign rom_write_enable  = wr_en_q;
  assign rom_write_address = addr_q;
  assign rom_write_data    = data_q;
  assign load_busy         = busy_q;
  assign load_done         = done_q;
  assign load_error        = error_q;
  assign cpu_enable        = cpu_en_q;

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Boot-time firmware writer for the instruction ROM.
- Receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes the words into the ROM write port at consecutive addresses, then releases the processor via cpu_enable.
- Sits between the external boot interface and the ROM inside the memory subsystem; replaces bench-side preloading of firmware_data.

Parameters:
- ADDR_WIDTH, 6, ROM word-address width; capacity 2^ADDR_WIDTH words (max 256).
- DATA_WIDTH, 32, instruction width; fixed at 32, 4 bytes per word.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load session.
- byte_in  input  8  stream byte.
- byte_valid  input  1  byte_in valid.
- byte_ready  output  1  loader accepts a byte this cycle.
- rom_write_enable  output  1  one-cycle ROM write strobe.
- rom_write_address  output  ADDR_WIDTH  ROM word address.
- rom_write_data  output  32  instruction word to write.
- load_busy  output  1  session in progress.
- load_done  output  1  level; load completed successfully.
- load_error  output  1  level; load failed.
- cpu_enable  output  1  processor run permission; high only when load_done is high.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all outputs 0; word index, byte counter, word count and checksum cleared. Reset mid-session abandons the session. Words already written to the ROM are not undone.
- Byte transfer occurs only on a cycle with byte_valid and byte_ready both high. byte_ready is high only in HEADER, DATA and CHECK.
- IDLE:
  - start -> HEADER.
  - byte_valid is ignored; a byte presented on the same cycle as start is not consumed.
- HEADER: accept byte N (number of words).
  - N==0 or N>2^ADDR_WIDTH -> ERROR.
  - Otherwise latch N, clear index and checksum -> DATA.
- DATA:
  - Accept 4 bytes. First byte goes to [31:24], last to [7:0].
  - Each accepted byte is XORed into the 8-bit checksum register.
  - After the 4th byte -> WRITE.
- WRITE (exactly 1 cycle, byte_ready=0):
  - rom_write_enable=1, rom_write_address=index, rom_write_data=assembled word.
  - index increments. index==N -> CHECK; otherwise -> DATA.
  - Address and data hold their last value outside WRITE; only the strobe is meaningful.
- CHECK: accept 1 byte.
  - Byte equals checksum -> DONE; otherwise -> ERROR.
- DONE: load_done=1, cpu_enable=1, load_busy=0.
- ERROR: load_error=1, cpu_enable=0, load_busy=0.
- Restart: start in DONE or ERROR clears load_done, load_error and cpu_enable -> HEADER. start in HEADER, DATA, WRITE or CHECK is ignored.
- load_busy=1 in HEADER, DATA, WRITE and CHECK.
- Timing:
  - Write strobe asserts the cycle after the 4th byte of a word is accepted.
  - DONE or ERROR is entered the cycle after the checksum byte is accepted.
  - ERROR from a bad header is entered the cycle after the header is accepted.
- No timeout: a stalled stream leaves the loader waiting indefinitely.

Optional Feature:
- Macro: ROM_LOADER_CHECKSUM_EN.
- Defined: CHECK state and trailing checksum byte exist as above.
- Undefined:
  - No checksum register and no CHECK state; no trailing byte is expected.
  - WRITE with index==N goes directly to DONE.
  - load_error is raised only by a bad header.

Test Plan:
1. Nominal load (feature on). start, then bytes 02,20,01,00,0D,20,02,00,0F,01 -> write addr0=0x2001000D, write addr1=0x2002000F, one cycle each; then load_done=1, cpu_enable=1, load_busy=0.
2. Bad checksum. Same stream with final byte 0x00 -> both writes occur; load_error=1, cpu_enable=0, load_done=0.
3. Bad header.
   - Header 0x00 -> ERROR the next cycle, no rom_write_enable.
   - Header 0x41 (65, ADDR_WIDTH=6) -> ERROR, no write.
4. Back-pressure and gaps. Nominal stream with byte_valid toggled every other cycle -> identical writes and result; byte_ready=0 during each WRITE cycle; no byte lost or duplicated.
5. Reset mid-session. Assert reset after 2 data bytes -> all outputs 0 immediately (asynchronous); then a full nominal load succeeds with the correct words at addr0/addr1.
6. Restart and feature off.
   - start pulse in DONE -> load_done and cpu_enable drop; a new 1-word load (01,FF,FF,FF,FF, checksum 0x00) writes addr0=0xFFFFFFFF.
   - With ROM_LOADER_CHECKSUM_EN undefined, stream 01,00,00,00,2A -> write addr0=0x0000002A, DONE with no extra byte.
